// File: rtl/bsg_mesh_router_input_fifo.sv
// -----------------------------------------------------------------------------
// bsg_mesh_router_input_fifo
//
// Per-direction input buffer placed directly upstream of bsg_mesh_router. It
// takes flits from the inter-tile link with valid/ready and offers them to the
// router with valid/yumi. Flits are stored and forwarded bit-for-bit, so the
// destination x/y fields in the low bits reach the router's decoder intact.
//
// Handshake rules:
//   link side   : a flit is enqueued on a rising clock edge when v_i & ready_o.
//                 v_i while ready_o = 0 is not an enqueue; the link must hold
//                 the flit and retry.
//   router side : the head flit is dequeued on a rising clock edge when
//                 yumi_i & v_o. yumi_i while v_o = 0 is ignored.
//   No output depends combinationally on v_i or yumi_i, so the router's yumi
//   loop cannot close through this block.
//
// Parameters:
//   width_p  flit width in bits (must be set by the instantiating module)
//   els_p    buffer depth, any integer >= 2 (not necessarily a power of two)
//   debug_p  1 enables a simulation-only check against yumi_i on an empty head
//
// Ports:
//   clk_i     in   1               clock
//   reset_i   in   1               asynchronous, active-high reset
//   v_i       in   1               link-side flit valid
//   data_i    in   width_p         link-side flit
//   ready_o   out  1               buffer can accept a flit this cycle
//   v_o       out  1               head flit valid (router v_i[dir])
//   data_o    out  width_p         head flit (router data_i[dir])
//   yumi_i    in   1               router consumed the head flit
//   count_o   out  clog2(els_p+1)  current occupancy, 0..els_p
// -----------------------------------------------------------------------------
module bsg_mesh_router_input_fifo #(
    parameter int width_p = -1,
    parameter int els_p   = 2,
    parameter int debug_p = 0,
    // An unset width_p collapses to one bit so that stand-alone elaboration
    // still produces legal ranges; real instances always override it.
    localparam int width_lp   = (width_p > 0) ? width_p : 1,
    localparam int ptr_w_lp   = $clog2(els_p),
    localparam int count_w_lp = $clog2(els_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  v_i,
    input  logic [width_lp-1:0]   data_i,
    output logic                  ready_o,

    output logic                  v_o,
    output logic [width_lp-1:0]   data_o,
    input  logic                  yumi_i,

    output logic [count_w_lp-1:0] count_o
);

    // Last legal pointer value; pointers wrap here explicitly so that depths
    // that are not a power of two never address a slot past els_p-1.
    localparam logic [ptr_w_lp-1:0]   last_ptr_lp   = ptr_w_lp'(els_p - 1);
    localparam logic [count_w_lp-1:0] full_count_lp = count_w_lp'(els_p);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [width_lp-1:0]   mem [els_p];
    logic [ptr_w_lp-1:0]   wptr;
    logic [ptr_w_lp-1:0]   rptr;
    logic [count_w_lp-1:0] count_r;

    // -------------------------------------------------------------------------
    // Decode of registered state
    // -------------------------------------------------------------------------
    logic full;
    logic empty;
    logic enq;
    logic deq;

    assign full  = (count_r == full_count_lp);
    assign empty = (count_r == '0);

    // Full means not ready even when the router dequeues in the same cycle:
    // the freed slot is offered one cycle later. This keeps ready_o free of
    // any path from yumi_i.
    assign ready_o = ~full & ~reset_i;
    assign v_o     = ~empty;
    assign data_o  = mem[rptr];
    assign count_o = count_r;

    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Storage: written only on enqueue, contents deliberately not reset since
    // data_o is meaningless whenever v_o is low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr] <= data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr <= '0;
        end else if (enq) begin
            wptr <= ptr_inc(wptr);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr <= '0;
        end else if (deq) begin
            rptr <= ptr_inc(rptr);
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy: a simultaneous enqueue and dequeue leaves it unchanged while
    // both pointers still advance.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else begin
            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Optional protocol check: the router must never consume an empty head.
    // -------------------------------------------------------------------------
    if (debug_p != 0) begin : g_debug
        assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
            else $fatal(1, "bsg_mesh_router_input_fifo: yumi_i asserted with v_o low");
    end

endmodule

// File: tb/tb_bsg_mesh_router_input_fifo.sv
module tb_bsg_mesh_router_input_fifo;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk;
    logic reset_i;
    logic v_i;
    logic [15:0] data_i;
    logic yumi_i;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two depths share the same stimulus; each has its own outputs.
    logic        ready2, v2;
    logic [15:0] data2;
    logic [1:0]  count2;
    logic        ready3, v3;
    logic [15:0] data3;
    logic [1:0]  count3;

    bsg_mesh_router_input_fifo #(.width_p(16), .els_p(2), .debug_p(0)) dut2 (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready2),
        .v_o     (v2),
        .data_o  (data2),
        .yumi_i  (yumi_i),
        .count_o (count2)
    );

    bsg_mesh_router_input_fifo #(.width_p(16), .els_p(3), .debug_p(0)) dut3 (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready3),
        .v_o     (v3),
        .data_o  (data3),
        .yumi_i  (yumi_i),
        .count_o (count3)
    );

    // ------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_q2[$];
    logic [15:0] exp_q3[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    // Advance to just after the next rising edge; outputs are stable there
    // and inputs driven there are sampled at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        step();
        step();
        reset_i = 1'b0;
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors for the depth-2 buffer. Each row: expected outputs
    // observed before the row's inputs take effect, then inputs for the edge.
    // ------------------------------------------------------------------------
    typedef struct {
        logic        v;
        logic [15:0] data;
        logic        yumi;
        logic        exp_v;
        logic [15:0] exp_data;
        logic        exp_ready;
        logic [1:0]  exp_count;
    } vec_t;

    vec_t vecs[12];

    // Expected-state helpers for the reference model (plain queue rules).
    function automatic logic [31:0] head_of(input logic [15:0] q[$]);
        return (q.size() != 0) ? {16'h0, q[0]} : 32'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        int enq2, deq2, enq3, deq3;

        //               v     data      yumi  exp_v exp_data  rdy   cnt
        vecs[0]  = '{1'b1, 16'h0305, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 16'hA001, 1'b1, 1'b1, 16'h0305, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 16'hA002, 1'b0, 1'b1, 16'hA001, 1'b1, 2'd1};
        vecs[3]  = '{1'b1, 16'hA003, 1'b0, 1'b1, 16'hA001, 1'b0, 2'd2};
        vecs[4]  = '{1'b1, 16'hA004, 1'b1, 1'b1, 16'hA001, 1'b0, 2'd2};
        vecs[5]  = '{1'b1, 16'hA004, 1'b0, 1'b1, 16'hA002, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA004, 1'b1, 2'd1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0};
        vecs[9]  = '{1'b1, 16'hB0B0, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hB0B0, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hB0B0, 1'b1, 2'd1};

        // ---------------- reset state ----------------
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        step();
        step();
        check("reset_v", v2, 1'b0);
        check("reset_ready", ready2, 1'b0);
        check("reset_count", count2, 2'd0);
        reset_i = 1'b0;
        #1;
        check("release_ready", ready2, 1'b1);
        check("release_v", v2, 1'b0);

        // ---------------- table-driven vectors (depth 2) ----------------
        for (int i = 0; i < 12; i++) begin
            check($sformatf("row%0d_v", i), v2, vecs[i].exp_v);
            check($sformatf("row%0d_ready", i), ready2, vecs[i].exp_ready);
            check($sformatf("row%0d_count", i), count2, vecs[i].exp_count);
            if (vecs[i].exp_v)
                check($sformatf("row%0d_data", i), data2, vecs[i].exp_data);
            v_i    = vecs[i].v;
            data_i = vecs[i].data;
            yumi_i = vecs[i].yumi;
            step();
        end

        // ---------------- async reset with two flits buffered ----------------
        apply_reset();
        v_i = 1'b1; data_i = 16'hC001;
        step();
        data_i = 16'hC002;
        step();
        v_i = 1'b0;
        check("arst_pre_count", count2, 2'd2);
        check("arst_pre_v", v2, 1'b1);
        #2 reset_i = 1'b1;
        #1;
        check("arst_v_now", v2, 1'b0);
        check("arst_count_now", count2, 2'd0);
        check("arst_ready_now", ready2, 1'b0);
        #1 reset_i = 1'b0;
        #1;
        check("arst_release_ready", ready2, 1'b1);
        step();
        check("arst_after_v", v2, 1'b0);
        v_i = 1'b1; data_i = 16'hD00D;
        step();
        v_i = 1'b0;
        check("arst_first_v", v2, 1'b1);
        check("arst_first_data", data2, 16'hD00D);
        check("arst_first_count", count2, 2'd1);
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check("arst_drained_v", v2, 1'b0);

        // ---------------- streaming with wrap (depth 3) ----------------
        apply_reset();
        exp_q.delete();
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (got == 10) break;
            check("stream_count_le1", (count3 <= 2'd1), 1'b1);
            v_i    = (sent < 10);
            data_i = 16'(sent);
            yumi_i = v3;
            if (yumi_i && v3) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_flit", 1'b1, 1'b0);
                end else begin
                    check($sformatf("stream_data%0d", got), data3, exp_q.pop_front());
                end
                got++;
            end
            if (v_i && ready3) begin
                exp_q.push_back(data_i);
                sent++;
            end
            step();
        end
        v_i = 1'b0;
        yumi_i = 1'b0;
        check("stream_all_received", got, 10);

        // ---------------- randomized run against queue models ----------------
        apply_reset();
        exp_q2.delete();
        exp_q3.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rnd2_v", v2, exp_q2.size() != 0);
            check("rnd2_count", count2, exp_q2.size());
            check("rnd2_ready", ready2, exp_q2.size() != 2);
            if (exp_q2.size() != 0) check("rnd2_data", data2, head_of(exp_q2));
            check("rnd3_v", v3, exp_q3.size() != 0);
            check("rnd3_count", count3, exp_q3.size());
            check("rnd3_ready", ready3, exp_q3.size() != 3);
            if (exp_q3.size() != 0) check("rnd3_data", data3, head_of(exp_q3));

            v_i    = ($urandom_range(0, 99) < 60);
            yumi_i = ($urandom_range(0, 99) < 55);
            data_i = 16'($urandom_range(0, 65535));

            enq2 = (v_i && exp_q2.size() != 2) ? 1 : 0;
            deq2 = (yumi_i && exp_q2.size() != 0) ? 1 : 0;
            enq3 = (v_i && exp_q3.size() != 3) ? 1 : 0;
            deq3 = (yumi_i && exp_q3.size() != 0) ? 1 : 0;
            if (deq2 != 0) void'(exp_q2.pop_front());
            if (enq2 != 0) exp_q2.push_back(data_i);
            if (deq3 != 0) void'(exp_q3.pop_front());
            if (enq3 != 0) exp_q3.push_back(data_i);
            step();
        end
        v_i = 1'b0;
        yumi_i = 1'b0;

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
